// File: rtl/r5p_mouse_rst_debounce.sv
// Board reset conditioner: synchronizes and debounces a push-button, then stretches the SoC reset.
// Define R5P_MOUSE_RST_COUNT_EN to add the saturating button-reset counter output rst_cnt.
module r5p_mouse_rst_debounce #(
    parameter int SYNC_FF = 2,
    parameter int DEB_CNT = 270000,
    parameter int RST_LEN = 16,
    parameter int BTN_POL = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_i,
    output logic       btn_o,
`ifdef R5P_MOUSE_RST_COUNT_EN
    output logic [7:0] rst_cnt,
`endif
    output logic       rst_o
);

    localparam int DW = $clog2(DEB_CNT + 1);
    localparam int SW = $clog2(RST_LEN + 1);
    localparam logic POL_INV = (BTN_POL == 0) ? 1'b1 : 1'b0;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT - 1);
    localparam logic [SW-1:0] STR_LAST = SW'(RST_LEN - 1);
    localparam logic [SW-1:0] STR_ONE  = SW'(1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STRETCH = 2'd1,
        RUN     = 2'd2
    } state_e;

    logic [SYNC_FF-1:0] sync_q, sync_d;
    logic               btn_q, btn_d;
    logic [DW-1:0]      dcnt_q, dcnt_d;
    state_e             state_q, state_d;
    logic [SW-1:0]      scnt_q, scnt_d;
    logic               rst_o_q, rst_o_d;
    logic               sync_s;

    assign sync_s = sync_q[SYNC_FF-1];

    // Synchronizer shift and debounce stability counter.
    always_comb begin
        sync_d = {sync_q[SYNC_FF-2:0], btn_i ^ POL_INV};
        btn_d  = btn_q;
        dcnt_d = dcnt_q;
        if (sync_s == btn_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DEB_LAST) begin
            btn_d  = ~btn_q;
            dcnt_d = '0;
        end else begin
            dcnt_d = dcnt_q + DW'(1);
        end
    end

    // Reset FSM next state; leaving HOLD already counts as the first stretch cycle.
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        rst_o_d = 1'b1;
        case (state_q)
            HOLD: begin
                scnt_d = '0;
                if (btn_q) begin
                    state_d = HOLD;
                end else if (STR_LAST == '0) begin
                    state_d = RUN;
                    rst_o_d = 1'b0;
                end else begin
                    state_d = STRETCH;
                    scnt_d  = STR_ONE;
                end
            end
            STRETCH: begin
                if (btn_q) begin
                    state_d = HOLD;
                    scnt_d  = '0;
                end else if (scnt_q == STR_LAST) begin
                    state_d = RUN;
                    scnt_d  = '0;
                    rst_o_d = 1'b0;
                end else begin
                    scnt_d  = scnt_q + STR_ONE;
                end
            end
            RUN: begin
                scnt_d = '0;
                if (btn_q) begin
                    state_d = HOLD;
                end else begin
                    rst_o_d = 1'b0;
                end
            end
            default: begin
                state_d = STRETCH;
                scnt_d  = '0;
            end
        endcase
    end

    // State registers; rst_o is asynchronously set so it rises without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            btn_q   <= 1'b0;
            dcnt_q  <= '0;
            state_q <= STRETCH;
            scnt_q  <= '0;
            rst_o_q <= 1'b1;
        end else begin
            sync_q  <= sync_d;
            btn_q   <= btn_d;
            dcnt_q  <= dcnt_d;
            state_q <= state_d;
            scnt_q  <= scnt_d;
            rst_o_q <= rst_o_d;
        end
    end

    assign btn_o = btn_q;
    assign rst_o = rst_o_q;

`ifdef R5P_MOUSE_RST_COUNT_EN
    logic [7:0] cnt_q, cnt_d;

    // Count RUN->HOLD transitions, saturating at 255.
    always_comb begin
        if ((state_q == RUN) && btn_q && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Button-reset counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rst_cnt = cnt_q;
`endif

endmodule
